// File: rtl/fmpad_pkg.sv
// Shared beat classification and dimension helpers for the feature-map padding stream.
package fmpad_pkg;

  typedef enum logic {
    BEAT_PAD      = 1'b0,
    BEAT_INTERIOR = 1'b1
  } beat_class_e;

  // Padded extent along one axis (OUT_W from IN_W/PAD_L/PAD_R, OUT_H from IN_H/PAD_T/PAD_B).
  function automatic int out_dim(input int in_dim, input int pad_lo, input int pad_hi);
    return pad_lo + in_dim + pad_hi;
  endfunction

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/fmpad_out_reg.sv
// Single-slot valid/data output register; refills in the same cycle its beat is consumed.
module fmpad_out_reg #(
  parameter int W = 8
) (
  input  logic         ap_clk,
  input  logic         ap_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         can_load,
  output logic         valid,
  output logic [W-1:0] data,
  input  logic         ready
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  assign can_load = !valid_reg || ready;
  assign valid    = valid_reg;
  assign data     = data_reg;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (can_load) begin
      valid_reg <= load;
      if (load) data_reg <= load_data;
    end
  end

endmodule

// File: rtl/fmpadding_stream.sv
// Streams a frame surrounded by zero borders; pad beats are generated locally, interior beats pass through.
module fmpadding_stream
  import fmpad_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int SIMD      = 1,
  parameter int CH_FOLD   = 1,
  parameter int IN_W      = 254,
  parameter int IN_H      = 254,
  parameter int PAD_T     = 1,
  parameter int PAD_B     = 1,
  parameter int PAD_L     = 1,
  parameter int PAD_R     = 1
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      in0_V_V_TVALID,
  output logic                      in0_V_V_TREADY,
  input  logic [BIT_WIDTH*SIMD-1:0] in0_V_V_TDATA,
  output logic                      out_V_V_TVALID,
  input  logic                      out_V_V_TREADY,
  output logic [BIT_WIDTH*SIMD-1:0] out_V_V_TDATA
);

  localparam int DW    = BIT_WIDTH * SIMD;
  localparam int OUT_W = out_dim(IN_W, PAD_L, PAD_R);
  localparam int OUT_H = out_dim(IN_H, PAD_T, PAD_B);
  localparam int FW    = cnt_width(CH_FOLD - 1);
  localparam int XW    = cnt_width(OUT_W - 1);
  localparam int YW    = cnt_width(OUT_H - 1);

  localparam logic [FW-1:0] F_LAST = FW'(CH_FOLD - 1);
  localparam logic [XW-1:0] X_LAST = XW'(OUT_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(OUT_H - 1);

  logic [FW-1:0] f_reg;
  logic [XW-1:0] x_reg;
  logic [YW-1:0] y_reg;

  beat_class_e   beat_class;
  int            x_rel;
  int            y_rel;
  logic          can_load;
  logic          load;
  logic [DW-1:0] load_data;

  // Signed offsets into the unpadded frame keep the bounds test valid for zero pads.
  always_comb begin
    x_rel      = int'(x_reg) - PAD_L;
    y_rel      = int'(y_reg) - PAD_T;
    beat_class = BEAT_PAD;
    if (x_rel >= 0 && x_rel < IN_W && y_rel >= 0 && y_rel < IN_H)
      beat_class = BEAT_INTERIOR;
  end

  assign in0_V_V_TREADY = (beat_class == BEAT_INTERIOR) && can_load && ap_rst_n;
  assign load           = (beat_class == BEAT_PAD) ? can_load
                                                   : (in0_V_V_TVALID && in0_V_V_TREADY);
  assign load_data      = (beat_class == BEAT_INTERIOR) ? in0_V_V_TDATA : '0;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      f_reg <= '0;
      x_reg <= '0;
      y_reg <= '0;
    end else if (load) begin
      if (f_reg == F_LAST) begin
        f_reg <= '0;
        if (x_reg == X_LAST) begin
          x_reg <= '0;
          y_reg <= (y_reg == Y_LAST) ? '0 : y_reg + 1'b1;
        end else begin
          x_reg <= x_reg + 1'b1;
        end
      end else begin
        f_reg <= f_reg + 1'b1;
      end
    end
  end

  fmpad_out_reg #(
    .W(DW)
  ) u_out_reg (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .load     (load),
    .load_data(load_data),
    .can_load (can_load),
    .valid    (out_V_V_TVALID),
    .data     (out_V_V_TDATA),
    .ready    (out_V_V_TREADY)
  );

endmodule

// File: tb/tb_fmpadding_stream.sv
// Randomized self-checking bench for fmpadding_stream against a raster-order padding model.
module tb_fmpadding_stream;

  // Three configurations: 4x3 pads=1, 3x1 pads=1 CH_FOLD=2, 2x2 no pads.
  localparam int IW [3] = '{4, 3, 2};
  localparam int IH [3] = '{3, 1, 2};
  localparam int PT [3] = '{1, 1, 0};
  localparam int PB [3] = '{1, 1, 0};
  localparam int PL [3] = '{1, 1, 0};
  localparam int PR [3] = '{1, 1, 0};
  localparam int CF [3] = '{1, 2, 1};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [7:0] in_data   [3];
  logic [7:0] out_data  [3];

  int passed = 0;
  int total  = 0;

  logic [7:0] in_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] out_q[$];
  int         in_cyc_q[$];
  int         out_cyc_q[$];
  int sent, got, unstable, ready_cycles, gap_cycles;

  always #5 clk = ~clk;

  fmpadding_stream #(.BIT_WIDTH(8), .SIMD(1), .CH_FOLD(1), .IN_W(4), .IN_H(3),
                     .PAD_T(1), .PAD_B(1), .PAD_L(1), .PAD_R(1)) dut_a (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in0_V_V_TVALID(in_valid[0]), .in0_V_V_TREADY(in_ready[0]), .in0_V_V_TDATA(in_data[0]),
    .out_V_V_TVALID(out_valid[0]), .out_V_V_TREADY(out_ready[0]), .out_V_V_TDATA(out_data[0]));

  fmpadding_stream #(.BIT_WIDTH(8), .SIMD(1), .CH_FOLD(2), .IN_W(3), .IN_H(1),
                     .PAD_T(1), .PAD_B(1), .PAD_L(1), .PAD_R(1)) dut_b (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in0_V_V_TVALID(in_valid[1]), .in0_V_V_TREADY(in_ready[1]), .in0_V_V_TDATA(in_data[1]),
    .out_V_V_TVALID(out_valid[1]), .out_V_V_TREADY(out_ready[1]), .out_V_V_TDATA(out_data[1]));

  fmpadding_stream #(.BIT_WIDTH(8), .SIMD(1), .CH_FOLD(1), .IN_W(2), .IN_H(2),
                     .PAD_T(0), .PAD_B(0), .PAD_L(0), .PAD_R(0)) dut_c (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .in0_V_V_TVALID(in_valid[2]), .in0_V_V_TREADY(in_ready[2]), .in0_V_V_TDATA(in_data[2]),
    .out_V_V_TVALID(out_valid[2]), .out_V_V_TREADY(out_ready[2]), .out_V_V_TDATA(out_data[2]));

  // Reference: walk the padded frame in raster order, interior beats take the next input.
  task automatic build_exp(input int id, input int frames);
    int k;
    k = 0;
    exp_q.delete();
    for (int fr = 0; fr < frames; fr++)
      for (int y = 0; y < PT[id] + IH[id] + PB[id]; y++)
        for (int x = 0; x < PL[id] + IW[id] + PR[id]; x++)
          for (int f = 0; f < CF[id]; f++)
            if (y >= PT[id] && y < PT[id] + IH[id] && x >= PL[id] && x < PL[id] + IW[id]) begin
              exp_q.push_back(in_q[k]);
              k++;
            end else begin
              exp_q.push_back(8'd0);
            end
  endtask

  task automatic fill_random(input int n);
    in_q.delete();
    for (int i = 0; i < n; i++) in_q.push_back(8'($urandom_range(1, 255)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_data[i] = 8'd0;
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Drives one DUT (vmode 0 steady, 1 stall window, 2 random; rmode 0 ready, 1 toggle, 2 random).
  task automatic run_dut(input int id, input int n_out, input int vmode, input int rmode,
                         input int stall_at, input int stall_len);
    int cyc, stall_cnt;
    logic prev_stall;
    logic [7:0] prev_data;
    out_q.delete(); in_cyc_q.delete(); out_cyc_q.delete();
    sent = 0; got = 0; unstable = 0; ready_cycles = 0; gap_cycles = 0;
    cyc = 0; stall_cnt = 0; prev_stall = 1'b0; prev_data = 8'd0;
    while (got < n_out && cyc < 3000) begin
      if (sent < in_q.size()) begin
        in_data[id] = in_q[sent];
        if (vmode == 0) in_valid[id] = 1'b1;
        else if (vmode == 1) begin
          if (sent == stall_at && stall_cnt < stall_len) begin
            in_valid[id] = 1'b0; stall_cnt++;
          end else in_valid[id] = 1'b1;
        end else in_valid[id] = ($urandom_range(0, 3) != 0);
      end else begin
        in_data[id] = 8'd0; in_valid[id] = 1'b0;
      end
      if (rmode == 0) out_ready[id] = 1'b1;
      else if (rmode == 1) out_ready[id] = (cyc % 2 == 0);
      else out_ready[id] = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_stall && (out_valid[id] !== 1'b1 || out_data[id] !== prev_data)) unstable++;
      prev_stall = out_valid[id] && !out_ready[id];
      prev_data  = out_data[id];
      if (in_ready[id] === 1'b1) ready_cycles++;
      if (in_valid[id] && in_ready[id] === 1'b1) begin in_cyc_q.push_back(cyc); sent++; end
      if (out_valid[id] !== 1'b1 && got > 0 && got < n_out) gap_cycles++;
      if (out_valid[id] === 1'b1 && out_ready[id]) begin
        out_q.push_back(out_data[id]); out_cyc_q.push_back(cyc); got++;
      end
      @(posedge clk);
      #1 cyc++;
    end
    in_valid[id] = 1'b0; out_ready[id] = 1'b0;
  endtask

  task automatic test_reset();
    int bad;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b1; out_ready[i] = 1'b1; in_data[i] = 8'hA5;
    end
    repeat (3) @(negedge clk);
    bad = 0;
    for (int i = 0; i < 3; i++) if (out_valid[i] !== 1'b0) bad++;
    total++;
    if (bad !== 0) $display("FAIL reset_out_valid: %0d instances valid, required 0", bad); else passed++;
    bad = 0;
    for (int i = 0; i < 3; i++) if (in_ready[i] !== 1'b0) bad++;
    total++;
    if (bad !== 0) $display("FAIL reset_in_ready: %0d instances ready, required 0", bad); else passed++;
    bad = 0;
    for (int i = 0; i < 3; i++) if (out_data[i] !== 8'd0) bad++;
    total++;
    if (bad !== 0) $display("FAIL reset_out_data: %0d instances nonzero, required 0", bad); else passed++;
    $display("reset: checked valid/ready/data on 3 instances");
  endtask

  task automatic test_basic_frame();
    int bad;
    do_reset();
    in_q.delete();
    for (int i = 1; i <= 12; i++) in_q.push_back(8'(i));
    build_exp(0, 1);
    run_dut(0, 30, 0, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    total++;
    if (bad !== 0 || got !== 30) $display("FAIL basic_seq: %0d beats, %0d wrong, required 30 beats 0 wrong", got, bad); else passed++;
    total++;
    if (ready_cycles !== 12) $display("FAIL basic_tready_cycles: got %0d required 12", ready_cycles); else passed++;
    total++;
    if (got < 30 || out_q[7] !== 8'd1) $display("FAIL basic_row1_first: got %0d required 1", got < 30 ? -1 : int'(out_q[7])); else passed++;
    total++;
    if (got < 30 || out_q[22] !== 8'd12) $display("FAIL basic_row3_last: got %0d required 12", got < 30 ? -1 : int'(out_q[22])); else passed++;
    total++;
    if (gap_cycles !== 0) $display("FAIL basic_throughput: got %0d idle cycles required 0", gap_cycles); else passed++;
    $display("basic_frame: %0d beats out, %0d inputs, tready %0d cycles", got, sent, ready_cycles);
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    fill_random(12);
    build_exp(0, 1);
    run_dut(0, 30, 0, 1, 0, 0);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    total++;
    if (bad !== 0 || got !== 30) $display("FAIL toggle_seq: %0d beats, %0d wrong, required 30 beats 0 wrong", got, bad); else passed++;
    total++;
    if (unstable !== 0) $display("FAIL toggle_stable: got %0d changes while stalled required 0", unstable); else passed++;
    total++;
    if (sent !== 12) $display("FAIL toggle_inputs: got %0d accepted required 12", sent); else passed++;
    $display("backpressure: %0d beats out, %0d inputs accepted", got, sent);
  endtask

  task automatic test_input_stall();
    int bad, idx6;
    do_reset();
    in_q.delete();
    for (int i = 1; i <= 12; i++) in_q.push_back(8'(i));
    build_exp(0, 1);
    run_dut(0, 30, 1, 0, 5, 5);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    total++;
    if (bad !== 0 || got !== 30) $display("FAIL stall_seq: %0d beats, %0d wrong, required 30 beats 0 wrong", got, bad); else passed++;
    total++;
    if (gap_cycles !== 5) $display("FAIL stall_gap: got %0d idle cycles required 5", gap_cycles); else passed++;
    idx6 = 14;
    total++;
    if (got < 30 || out_cyc_q[idx6] - out_cyc_q[idx6-1] !== 6)
      $display("FAIL stall_resume: got spacing %0d required 6", got < 30 ? -1 : out_cyc_q[idx6] - out_cyc_q[idx6-1]);
    else passed++;
    $display("input_stall: %0d beats out, %0d idle output cycles", got, gap_cycles);
  endtask

  task automatic test_back_to_back();
    int bad;
    do_reset();
    fill_random(12);
    build_exp(1, 2);
    run_dut(1, 60, 0, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    total++;
    if (bad !== 0 || got !== 60) $display("FAIL b2b_seq: %0d beats, %0d wrong, required 60 beats 0 wrong", got, bad); else passed++;
    total++;
    if (got < 60 || out_q[30] !== 8'd0) $display("FAIL b2b_second_first: got %0d required 0", got < 60 ? -1 : int'(out_q[30])); else passed++;
    total++;
    if (got < 60 || out_cyc_q[30] !== out_cyc_q[29] + 1)
      $display("FAIL b2b_no_bubble: got spacing %0d required 1", got < 60 ? -1 : out_cyc_q[30] - out_cyc_q[29]);
    else passed++;
    $display("back_to_back: %0d beats out over two frames", got);
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    logic pre_valid;
    do_reset();
    fill_random(12);
    run_dut(0, 14, 0, 0, 0, 0);
    #2 pre_valid = out_valid[0];
    rst_n = 1'b0;
    #1;
    total++;
    if (pre_valid !== 1'b1 || out_valid[0] !== 1'b0)
      $display("FAIL midrst_valid_drop: before %0b after %0b required 1 then 0", pre_valid, out_valid[0]);
    else passed++;
    total++;
    if (in_ready[0] !== 1'b0 || out_data[0] !== 8'd0)
      $display("FAIL midrst_outputs: tready %0b data %0d required 0 and 0", in_ready[0], out_data[0]);
    else passed++;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    fill_random(12);
    build_exp(0, 1);
    run_dut(0, 30, 0, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    total++;
    if (bad !== 0 || got !== 30) $display("FAIL midrst_seq: %0d beats, %0d wrong, required 30 beats 0 wrong", got, bad); else passed++;
    $display("reset_mid_frame: restarted, %0d beats out after release", got);
  endtask

  task automatic test_no_pad();
    int bad;
    do_reset();
    fill_random(4);
    build_exp(2, 1);
    run_dut(2, 4, 0, 0, 0, 0);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    total++;
    if (bad !== 0 || got !== 4) $display("FAIL nopad_seq: %0d beats, %0d wrong, required 4 beats 0 wrong", got, bad); else passed++;
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (i >= in_cyc_q.size() || i >= out_cyc_q.size() || out_cyc_q[i] !== in_cyc_q[i] + 1) bad++;
    total++;
    if (bad !== 0) $display("FAIL nopad_latency: %0d beats not 1 cycle late, required 0", bad); else passed++;
    $display("no_pad: %0d beats passed through", got);
  endtask

  task automatic test_random();
    int bad;
    for (int it = 0; it < 3; it++) begin
      do_reset();
      fill_random(36);
      build_exp(0, 3);
      run_dut(0, 90, 2, 2, 0, 0);
      bad = 0;
      for (int i = 0; i < exp_q.size(); i++) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
      total++;
      if (bad !== 0 || got !== 90) $display("FAIL random_seq: iter %0d, %0d beats, %0d wrong, required 90 beats 0 wrong", it, got, bad); else passed++;
      total++;
      if (unstable !== 0) $display("FAIL random_stable: iter %0d, got %0d changes required 0", it, unstable); else passed++;
      $display("random iter %0d: %0d beats out, %0d inputs", it, got, sent);
    end
    do_reset();
    fill_random(12);
    build_exp(1, 2);
    run_dut(1, 60, 2, 2, 0, 0);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++) if (i >= out_q.size() || out_q[i] !== exp_q[i]) bad++;
    total++;
    if (bad !== 0 || got !== 60) $display("FAIL random_fold_seq: %0d beats, %0d wrong, required 60 beats 0 wrong", got, bad); else passed++;
    $display("random fold: %0d beats out, %0d inputs", got, sent);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; out_ready[i] = 1'b0; in_data[i] = 8'd0;
    end
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_input_stall();
    test_back_to_back();
    test_reset_mid_frame();
    test_no_pad();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fmpadding_stream.md
FMPADDING_STREAM -- requirements
Module: fmpadding_stream

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 8: bits per element.
REQ-002 The block SHALL have parameter SIMD, default 1: elements per stream beat.
REQ-003 The block SHALL have parameter CH_FOLD, default 1: beats per pixel, equal to channels/SIMD.
REQ-004 The block SHALL have parameters IN_W and IN_H, defaults 254 and 254: unpadded frame width and height in pixels.
REQ-005 The block SHALL have parameters PAD_T, PAD_B, PAD_L and PAD_R, default 1 each: zero rows/columns added on each side.
REQ-006 The block SHALL have port ap_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port ap_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port in0_V_V_TVALID, input, 1 bit: upstream beat valid.
REQ-009 The block SHALL have port in0_V_V_TREADY, output, 1 bit: beat accepted when high together with TVALID.
REQ-010 The block SHALL have port in0_V_V_TDATA, input, BIT_WIDTH*SIMD bits: upstream beat.
REQ-011 The block SHALL have port out_V_V_TVALID, output, 1 bit: padded-stream beat valid; feeds the sliding-window generator.
REQ-012 The block SHALL have port out_V_V_TREADY, input, 1 bit: downstream ready.
REQ-013 The block SHALL have port out_V_V_TDATA, output, BIT_WIDTH*SIMD bits: padded beat.

Function
REQ-014 Output frame SHALL be OUT_W=PAD_L+IN_W+PAD_R by OUT_H=PAD_T+IN_H+PAD_B pixels, emitted raster order, CH_FOLD beats per pixel.
REQ-015 Counters f (0..CH_FOLD-1), x (0..OUT_W-1) and y (0..OUT_H-1) SHALL index the next beat to load; widths are $clog2(max+1).
REQ-016 A beat SHALL be INTERIOR iff PAD_L<=x<PAD_L+IN_W and PAD_T<=y<PAD_T+IN_H; otherwise it is PAD.
REQ-017 Output SHALL be a single registered stage (data plus valid); the stage may load when empty or when its current beat is consumed in the same cycle (out TVALID&&TREADY).
REQ-018 For a PAD beat, when the stage may load, it SHALL load all-zero data and advance counters without consuming input.
REQ-019 For an INTERIOR beat, in0_V_V_TREADY SHALL equal (stage may load) and (ap_rst_n high); on handshake the stage loads TDATA and counters advance.
REQ-020 in0_V_V_TREADY SHALL be 0 during PAD beats, so no input is ever dropped or duplicated.
REQ-021 Latency SHALL be exactly 1 cycle from input handshake (or PAD load decision) to out_V_V_TVALID.
REQ-022 With no backpressure and a continuous input stream, throughput SHALL be 1 beat/cycle, including across row and frame boundaries.
REQ-023 Counter advance SHALL be: f increments; at f=CH_FOLD-1, f wraps to 0 and x increments; at x=OUT_W-1, x wraps to 0 and y increments; at y=OUT_H-1, y wraps to 0 and the next frame starts with no idle cycle.
REQ-024 out_V_V_TDATA and out_V_V_TVALID SHALL stay stable while out_V_V_TVALID=1 and out_V_V_TREADY=0.
REQ-025 With any pad parameter equal to 0, the corresponding region SHALL be absent; with all pads 0 the block SHALL be a 1-cycle registered pass-through.

Reset
REQ-026 While ap_rst_n=0, out_V_V_TVALID=0, in0_V_V_TREADY=0, out_V_V_TDATA=0, and f=x=y=0.
REQ-027 Reset asserted mid-frame SHALL discard any buffered beat; after release, output restarts at the top-left pad pixel of a new frame.

Structure
REQ-028 A shared package fmpad_pkg SHALL hold the beat-class enum (BEAT_PAD, BEAT_INTERIOR) and a function that derives OUT_W and OUT_H.
REQ-029 The output register SHALL be a sub-module named fmpad_out_reg (valid/data/ready single-slot register); counters and classification stay in the top module.

Verification
REQ-030 IN_W=4, IN_H=3, pads=1, CH_FOLD=1, inputs 1..12, sinks always ready -> 30 beats out; rows 0 and 4 all zero; row 1 = 0,1,2,3,4,0; row 3 = 0,9,10,11,12,0; in TREADY high for exactly 12 cycles.
REQ-031 Same config, out_V_V_TREADY toggled 1-0-1-0 -> output sequence identical to REQ-030, data held stable whenever valid and not ready, no input lost.
REQ-032 Same config, in0_V_V_TVALID low for 5 cycles at the input for x=2, y=2 -> output stalls after the preceding beat, resumes with value 6, and total frame output is unchanged.
REQ-033 Two back-to-back frames with CH_FOLD=2 -> 60 beats out; second frame's first beat is zero immediately after first frame's last beat, with no bubble.
REQ-034 ap_rst_n pulsed low at output beat 14 -> TVALID drops asynchronously; after release, the first output beat is zero and the next 30 beats match REQ-030 for fresh input.
REQ-035 All pads=0, IN_W=IN_H=2 -> 4 beats out, each equal to its input one cycle later.
